// File: rtl/sa_run_controller_pkg.sv
// Shared definitions for the systolic-array run controller and its feeder control:
// state encoding, run-phase lengths and the step-index width.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } sa_state_t;

    localparam int RUN_COUNT_W = 16;

    // Step runs 0..3N-3, so 3N values must be representable.
    function automatic int cnt_w(input int n);
        return $clog2(3 * n);
    endfunction

    function automatic int feed_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_len(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/sa_run_controller_if.sv
// Host/array-side handshake bundle of the run controller.
// run_count exists only when SA_CTRL_PERF_EN is defined.
interface sa_run_controller_if
    import sa_pkg::*;
#(
    parameter int N = 8
);
    localparam int CNT_W = cnt_w(N);

    logic             start;
    logic             abort;
    logic             result_ack;
    logic             clr_acc;
    logic             sa_en;
    logic             feed_valid;
    logic [CNT_W-1:0] step;
    logic             busy;
    logic             done;
    logic             result_valid;
`ifdef SA_CTRL_PERF_EN
    logic [RUN_COUNT_W-1:0] run_count;
`endif

    modport master (
        output start, abort, result_ack,
        input  clr_acc, sa_en, feed_valid, step, busy, done, result_valid
`ifdef SA_CTRL_PERF_EN
        , input run_count
`endif
    );

    modport slave (
        input  start, abort, result_ack,
        output clr_acc, sa_en, feed_valid, step, busy, done, result_valid
`ifdef SA_CTRL_PERF_EN
        , output run_count
`endif
    );

endinterface

// File: rtl/sa_run_controller_step_counter.sv
// Loadable up-counter with synchronous clear, count enable and a terminal-match flag.
module sa_step_counter #(
    parameter int W = 4
) (
    input  logic         m_clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term_val,
    output logic [W-1:0] o_count,
    output logic         o_term
);

    logic [W-1:0] r_count;

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == i_term_val);

endmodule

// File: rtl/sa_run_controller.sv
// Run sequencer for the NxN systolic array: start/done handshake, array enable,
// accumulator clear and skew step. Optional run counter under SA_CTRL_PERF_EN.
module sa_run_controller
    import sa_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                m_clk,
    input  logic                rst,
    sa_run_controller_if.slave  bus
);

    localparam int               CNT_W      = cnt_w(N);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(feed_len(N) - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(feed_len(N) + drain_len(N) - 1);

    sa_state_t        r_state;
    sa_state_t        w_next_state;
    logic             r_result_valid;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] w_term_val;
    logic             w_term;
    logic             w_cnt_en;

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_cnt_en        = 1'b0;
        bus.clr_acc     = 1'b0;
        bus.sa_en       = 1'b0;
        bus.feed_valid  = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) w_next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                bus.clr_acc  = 1'b1;
                bus.busy     = 1'b1;
                w_next_state = bus.abort ? ST_IDLE : ST_FEED;
            end
            ST_FEED: begin
                bus.sa_en      = 1'b1;
                bus.feed_valid = 1'b1;
                bus.busy       = 1'b1;
                if (bus.abort)   w_next_state = ST_IDLE;
                else if (w_term) w_next_state = (N == 1) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.sa_en = 1'b1;
                bus.busy  = 1'b1;
                if (bus.abort)   w_next_state = ST_IDLE;
                else if (w_term) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                bus.done     = 1'b1;
                w_next_state = (bus.start && !bus.abort) ? ST_CLEAR : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Step keeps counting across FEED->DRAIN; any other move zeroes it.
        w_cnt_en = ((r_state == ST_FEED) || (r_state == ST_DRAIN)) &&
                   ((w_next_state == ST_FEED) || (w_next_state == ST_DRAIN));
    end

    assign w_term_val = (r_state == ST_DRAIN) ? DRAIN_LAST : FEED_LAST;

    sa_step_counter #(
        .W (CNT_W)
    ) u_step_counter (
        .m_clk      (m_clk),
        .rst        (rst),
        .i_clr      (!w_cnt_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_cnt_en),
        .i_term_val (w_term_val),
        .o_count    (w_step),
        .o_term     (w_term)
    );

    // An ack coincident with the done pulse loses to the completion being flagged.
    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            r_result_valid <= 1'b0;
        end else if (w_next_state == ST_CLEAR) begin
            r_result_valid <= 1'b0;
        end else if ((w_next_state == ST_DONE) || (r_state == ST_DONE)) begin
            r_result_valid <= 1'b1;
        end else if (bus.result_ack) begin
            r_result_valid <= 1'b0;
        end
    end

    assign bus.step         = w_step;
    assign bus.result_valid = r_result_valid;

`ifdef SA_CTRL_PERF_EN
    logic [RUN_COUNT_W-1:0] r_run_count;

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            r_run_count <= '0;
        end else if ((r_state == ST_DONE) && (r_run_count != {RUN_COUNT_W{1'b1}})) begin
            r_run_count <= r_run_count + 1'b1;
        end
    end

    assign bus.run_count = r_run_count;
`endif

endmodule

// File: tb/tb_sa_run_controller.sv
// Self-checking bench for sa_run_controller at N=1, 4 and 8 with a done-event scoreboard.
// Run-counter checks are compiled in when SA_CTRL_PERF_EN is defined.
module tb_sa_run_controller;

    logic m_clk = 1'b0;
    logic rst   = 1'b1;
    int   cyc   = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   q1[$];
    int   q4[$];
    int   q8[$];

    always #5 m_clk = ~m_clk;
    always @(posedge m_clk) cyc <= cyc + 1;

    sa_run_controller_if #(.N(1)) if1 ();
    sa_run_controller_if #(.N(4)) if4 ();
    sa_run_controller_if #(.N(8)) if8 ();

    sa_run_controller #(.N(1)) u1 (.m_clk(m_clk), .rst(rst), .bus(if1.slave));
    sa_run_controller #(.N(4)) u4 (.m_clk(m_clk), .rst(rst), .bus(if4.slave));
    sa_run_controller #(.N(8)) u8 (.m_clk(m_clk), .rst(rst), .bus(if8.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // {busy, clr_acc, sa_en, feed_valid, done, result_valid, step[6:0]}
    function automatic logic [12:0] obs(input int n);
        case (n)
            1: return {if1.busy, if1.clr_acc, if1.sa_en, if1.feed_valid, if1.done, if1.result_valid, 7'(if1.step)};
            4: return {if4.busy, if4.clr_acc, if4.sa_en, if4.feed_valid, if4.done, if4.result_valid, 7'(if4.step)};
            default: return {if8.busy, if8.clr_acc, if8.sa_en, if8.feed_valid, if8.done, if8.result_valid, 7'(if8.step)};
        endcase
    endfunction

    // Expected outputs k edges after the edge that entered CLEAR.
    function automatic logic [12:0] exp_trace(input int n, input int k);
        if (k == 0)           return {6'b110000, 7'd0};
        else if (k <= 2*n-1)  return {6'b101100, 7'(k-1)};
        else                  return {6'b101000, 7'(k-1)};
    endfunction

    function automatic logic [12:0] idle(input logic rv);
        return {5'b0, rv, 7'd0};
    endfunction

    task automatic next_pos();
        @(posedge m_clk); #1;
    endtask

    task automatic at_pos(input int t);
        do begin @(posedge m_clk); #1; end while (cyc < t);
    endtask

    task automatic at_neg(input int t);
        do @(negedge m_clk); while (cyc < t);
    endtask

    task automatic score(input int n, input int e, input logic rv);
        if (e < 0) begin
            n_total++;
            $display("FAIL done_unexpected_n%0d: got done at cycle %0d, required no done", n, cyc);
        end else begin
            check($sformatf("done_cycle_n%0d", n), cyc, e);
            check($sformatf("rv_at_done_n%0d", n), 32'(rv), 32'd1);
        end
    endtask

    // Monitor: every done pulse pops the next expected completion cycle.
    always @(negedge m_clk) begin
        if (if1.done) score(1, (q1.size() != 0) ? q1.pop_front() : -1, if1.result_valid);
        if (if4.done) score(4, (q4.size() != 0) ? q4.pop_front() : -1, if4.result_valid);
        if (if8.done) score(8, (q8.size() != 0) ? q8.pop_front() : -1, if8.result_valid);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int c;
        {if1.start, if1.abort, if1.result_ack} = 3'b000;
        {if4.start, if4.abort, if4.result_ack} = 3'b000;
        {if8.start, if8.abort, if8.result_ack} = 3'b000;
        repeat (2) @(negedge m_clk);
        check("reset_n1", 32'(obs(1)), 32'(idle(1'b0)));
        check("reset_n4", 32'(obs(4)), 32'(idle(1'b0)));
        check("reset_n8", 32'(obs(8)), 32'(idle(1'b0)));
        next_pos(); rst = 1'b0;

        // N=4 single run, ack coincident with done, then a real ack
        next_pos(); c = cyc; if4.start = 1'b1; q4.push_back(c + 12);
        next_pos(); if4.start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            at_neg(c + 1 + k);
            check($sformatf("n4_trace_k%0d", k), 32'(obs(4)), 32'(exp_trace(4, k)));
        end
        at_pos(c + 12); if4.result_ack = 1'b1;
        at_pos(c + 13); if4.result_ack = 1'b0;
        at_neg(c + 13); check("n4_ack_with_done_keeps_rv", 32'(obs(4)), 32'(idle(1'b1)));
        at_pos(c + 14); if4.result_ack = 1'b1;
        at_pos(c + 15); if4.result_ack = 1'b0;
        at_neg(c + 15); check("n4_second_ack_clears_rv", 32'(obs(4)), 32'(idle(1'b0)));

        // N=1 single run: CLEAR, FEED step 0, DONE
        next_pos(); c = cyc; if1.start = 1'b1; q1.push_back(c + 3);
        next_pos(); if1.start = 1'b0;
        for (int k = 0; k <= 1; k++) begin
            at_neg(c + 1 + k);
            check($sformatf("n1_trace_k%0d", k), 32'(obs(1)), 32'(exp_trace(1, k)));
        end
        at_neg(c + 4); check("n1_idle_after_done", 32'(obs(1)), 32'(idle(1'b1)));

        // N=1 abort during DONE while start is still high
        next_pos(); c = cyc; if1.start = 1'b1; q1.push_back(c + 3);
        at_pos(c + 3); if1.abort = 1'b1;
        at_pos(c + 4); if1.abort = 1'b0; if1.start = 1'b0;
        at_neg(c + 4); check("n1_abort_in_done_to_idle", 32'(obs(1)), 32'(idle(1'b1)));

        // N=8 start held: two back-to-back runs, 24-cycle period
        next_pos(); c = cyc; if8.start = 1'b1; q8.push_back(c + 24); q8.push_back(c + 48);
        at_neg(c + 1);  check("n8_run1_clear", 32'(obs(8)), 32'(exp_trace(8, 0)));
        at_neg(c + 25); check("n8_run2_clear_rv_low", 32'(obs(8)), 32'(exp_trace(8, 0)));
        at_pos(c + 30); if8.start = 1'b0;
        at_neg(c + 49); check("n8_idle_after_chain", 32'(obs(8)), 32'(idle(1'b1)));

        // N=8 abort at step 5 with start asserted in the same cycle
        next_pos(); c = cyc; if8.start = 1'b1;
        next_pos(); if8.start = 1'b0;
        at_pos(c + 7); if8.abort = 1'b1; if8.start = 1'b1;
        at_neg(c + 7); check("n8_step5_before_abort", 32'(obs(8)), 32'(exp_trace(8, 6)));
        at_pos(c + 8); if8.abort = 1'b0; if8.start = 1'b0;
        at_neg(c + 8); check("n8_abort_to_idle", 32'(obs(8)), 32'(idle(1'b0)));
        at_neg(c + 9); check("n8_abort_start_ignored", 32'(obs(8)), 32'(idle(1'b0)));

        // N=4 asynchronous reset in the middle of FEED
        next_pos(); c = cyc; if4.start = 1'b1;
        next_pos(); if4.start = 1'b0;
        at_neg(c + 5); check("n4_feed_step3", 32'(obs(4)), 32'(exp_trace(4, 4)));
        #2 rst = 1'b1;
        #1 check("n4_async_reset_midcycle", 32'(obs(4)), 32'(idle(1'b0)));
        next_pos(); rst = 1'b0;
        at_neg(cyc); check("n4_idle_after_reset", 32'(obs(4)), 32'(idle(1'b0)));

`ifdef SA_CTRL_PERF_EN
        check("run_count_after_reset", 32'(if4.run_count), 32'h0);
        next_pos(); force u4.r_run_count = 16'hFFFE;
        next_pos(); release u4.r_run_count;
        c = cyc; if4.start = 1'b1; q4.push_back(c + 12); q4.push_back(c + 24);
        at_pos(c + 13); if4.start = 1'b0;
        at_neg(c + 25); check("run_count_saturated", 32'(if4.run_count), 32'hFFFF);
        next_pos(); rst = 1'b1;
        #1 check("run_count_reset", 32'(if4.run_count), 32'h0);
        next_pos(); rst = 1'b0;
`endif

        at_neg(cyc + 30);
        check("n1_pending_done", 32'(q1.size()), 32'd0);
        check("n4_pending_done", 32'(q4.size()), 32'd0);
        check("n8_pending_done", 32'(q8.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sa_run_controller.md
# sa_run_controller

Parametrised run sequencer for the N×N systolic-array multiplier. It replaces the free-running cycle counter and gated-clock stop flag with a start/done handshake, a synchronous array enable, an accumulator clear and a skew-step index for the operand feeders. It sits between the host/test logic and the array plus its feeder control, and supports back-to-back runs and abort.

## Interface
- N, 8, array dimension (N ≥ 1); fixes the run length.
- CNT_W, $clog2(3*N), step index width (derived localparam, not overridable).
- m_clk  in  1  sole clock; every flop is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- abort  in  1  terminates an active run; has priority over start.
- result_ack  in  1  clears result_valid.
- clr_acc  out  1  one-cycle clear of array accumulators.
- sa_en  out  1  array clock enable; replaces clock gating.
- feed_valid  out  1  feeders drive operands this cycle; otherwise they drive zero.
- step  out  CNT_W  skew step; row/column i uses operand index step−i when 0 ≤ step−i < N.
- busy  out  1  high in CLEAR, FEED and DRAIN.
- done  out  1  one-cycle completion pulse.
- result_valid  out  1  array outputs hold a complete product.

## Operation
- States and transitions:
  - IDLE → CLEAR on start.
  - CLEAR → FEED, always after 1 cycle.
  - FEED lasts 2N−1 cycles, step 0..2N−2. It then goes to DRAIN, or straight to DONE if N=1.
  - DRAIN lasts N−1 cycles, step 2N−1..3N−3. It then goes to DONE.
  - DONE → CLEAR if start is high, otherwise → IDLE.
- Outputs by state:
  - IDLE: all outputs 0 except result_valid, which is held.
  - CLEAR: clr_acc=1, sa_en=0, step=0.
  - FEED: sa_en=1, feed_valid=1.
  - DRAIN: sa_en=1, feed_valid=0.
  - DONE: done=1, sa_en=0.
- step is 0 outside FEED and DRAIN. It never wraps, and the terminal value is 3N−3.
- result_valid:
  - set on entry to DONE;
  - cleared by result_ack or on entry to CLEAR;
  - if set and ack occur in the same cycle, set wins.
- abort in CLEAR, FEED or DRAIN: next state IDLE, no done pulse, result_valid stays 0. Accumulator contents are then undefined.
- abort in DONE: next state IDLE even if start is high.
- start is ignored while busy. It is level-sampled, so a start held high in DONE chains runs with no IDLE gap.

## Timing
- Reset (asynchronous): state IDLE; step=0; clr_acc, sa_en, feed_valid, busy, done and result_valid all 0.
- Control outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Latency: done is high in the cycle after 3N−1 rising edges past the edge that sampled start.
  - N=1: 2 edges.
  - N=4: 11 edges.
  - N=8: 23 edges.
- Back-to-back runs: run period is exactly 3N cycles (CLEAR through DONE).
- rst asserted mid-run: immediate return to the reset values. Deassertion is synchronised to m_clk by the integrator.

## Configuration
- SA_CTRL_PERF_EN defined:
  - adds output run_count (16 bits), reset to 0;
  - increments on each done pulse and saturates at 0xFFFF;
  - aborts are not counted.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package sa_pkg holds:
  - the state encoding (IDLE, CLEAR, FEED, DRAIN, DONE);
  - the functions feed_len(N)=2N−1 and drain_len(N)=N−1;
  - the CNT_W derivation, shared with the feeder control.
- One sub-module, sa_step_counter: loadable up-counter with synchronous clear, enable and a terminal-match flag. It is instantiated once for step.

## Test plan
- N=4, start pulse at edge E0:
  - clr_acc high in cycle 1;
  - step 0..6 with feed_valid;
  - step 7..9 with feed_valid=0 and sa_en=1;
  - done and result_valid rise 11 edges after E0.
- N=1, start pulse: CLEAR, then FEED (step 0), then DONE. done appears 2 edges after start, and DRAIN is never visited.
- N=8, start held high: done pulses every 24 cycles, clr_acc fires each run, result_valid toggles low on each CLEAR.
- N=8, abort at step 5: IDLE the next cycle, no done, result_valid=0. A start during that abort cycle is ignored.
- result_ack asserted in the same cycle done is high: result_valid = 1 afterwards. A second ack clears it.
- SA_CTRL_PERF_EN defined, run_count preset to 0xFFFE by forcing: two completed runs leave run_count = 0xFFFF; asserting rst returns it to 0.
